// File: rtl/simple_circuit_checker.sv
// On-board checker for Simple_Circuit: steps {A,B,C} through 000..111, waits a settle
// window per vector, and compares D/E against the golden model (D=(A&B)|~C, E=~C).
module simple_circuit_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  input  logic       d_in,
  input  logic       e_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] fail_vec
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LOAD =
    (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_d;
  logic       fail_valid_d;
  logic [2:0] fail_vec_d;
  logic       done_d, pass_d, busy_d;
  logic       exp_d, exp_e, mismatch;

  assign exp_d    = (vec_q[2] & vec_q[1]) | ~vec_q[0];
  assign exp_e    = ~vec_q[0];
  assign mismatch = (d_in != exp_d) || (e_in != exp_e);

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    err_d        = err_count;
    fail_valid_d = fail_valid;
    fail_vec_d   = fail_vec;
    done_d       = done;
    pass_d       = pass;
    unique case (state_q)
      IDLE, FINISH: begin
        if (start) begin
          state_d      = DRIVE;
          vec_d        = 3'd0;
          err_d        = 4'd0;
          fail_valid_d = 1'b0;
          fail_vec_d   = 3'd0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
        end
      end
      DRIVE: begin
        cnt_d   = SETTLE_LOAD;
        state_d = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      SAMPLE: begin
        if (mismatch) begin
          err_d = err_count + 4'd1;
          if (!fail_valid) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
          end
        end
        // pass is taken from the count including this last sample
        if (vec_q == 3'd7) begin
          state_d = FINISH;
          done_d  = 1'b1;
          pass_d  = (err_d == 4'd0);
        end else begin
          vec_d   = vec_q + 3'd1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d == DRIVE) || (state_d == SETTLE) || (state_d == SAMPLE);

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      vec_q      <= 3'd0;
      cnt_q      <= 4'd0;
      err_count  <= 4'd0;
      fail_valid <= 1'b0;
      fail_vec   <= 3'd0;
      done       <= 1'b0;
      pass       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      err_count  <= err_d;
      fail_valid <= fail_valid_d;
      fail_vec   <= fail_vec_d;
      done       <= done_d;
      pass       <= pass_d;
      busy       <= busy_d;
    end
  end

  assign a_out = vec_q[2];
  assign b_out = vec_q[1];
  assign c_out = vec_q[0];

endmodule

// File: tb/tb_simple_circuit_checker.sv
// Bench for simple_circuit_checker: two instances (settle 2 and settle 0) each facing a
// modelled Simple_Circuit that can be correct, faulty, or randomly corrupted per vector.
module tb_simple_circuit_checker;

  logic clk = 1'b0;
  logic reset, start, sel;
  always #5 clk = ~clk;

  // DUT with SETTLE_CYCLES=2
  logic start2, a2, b2, c2, d2, e2, busy2, done2, pass2, fv2;
  logic [3:0] err2;
  logic [2:0] fvec2;
  // DUT with SETTLE_CYCLES=0
  logic start0, a0, b0, c0, d0, e0, busy0, done0, pass0, fv0;
  logic [3:0] err0;
  logic [2:0] fvec0;

  assign start2 = start & ~sel;
  assign start0 = start & sel;

  simple_circuit_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start2),
    .a_out(a2), .b_out(b2), .c_out(c2), .d_in(d2), .e_in(e2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .fail_vec(fvec2)
  );

  simple_circuit_checker #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0),
    .a_out(a0), .b_out(b0), .c_out(c0), .d_in(d0), .e_in(e0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .fail_vec(fvec0)
  );

  // Circuit behaviour: 0 correct, 1 D stuck at 0, 2 E wired to C, 3 random flips per vector
  int         mode;
  logic [7:0] flip_d, flip_e;
  logic [7:0] d_tbl, e_tbl;

  function automatic logic [1:0] circuit(input logic [2:0] v);
    logic d, e;
    d = d_tbl[v];
    e = e_tbl[v];
    case (mode)
      1: d = 1'b0;
      2: e = v[0];
      3: begin d = d ^ flip_d[v]; e = e ^ flip_e[v]; end
      default: ;
    endcase
    return {d, e};
  endfunction

  always_comb {d2, e2} = circuit({a2, b2, c2});
  always_comb {d0, e0} = circuit({a0, b0, c0});

  // Observation mux onto the selected instance
  logic       o_busy, o_done, o_pass, o_fv;
  logic [2:0] o_abc, o_fvec;
  logic [3:0] o_err;
  always_comb begin
    o_busy = sel ? busy0 : busy2;
    o_done = sel ? done0 : done2;
    o_pass = sel ? pass0 : pass2;
    o_fv   = sel ? fv0 : fv2;
    o_abc  = sel ? {a0, b0, c0} : {a2, b2, c2};
    o_fvec = sel ? fvec0 : fvec2;
    o_err  = sel ? err0 : err2;
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what the checker should conclude, from the golden equations directly
  task automatic expect_result(output int err, output int first);
    logic [1:0] r;
    logic gd, ge;
    err   = 0;
    first = 0;
    for (int v = 0; v < 8; v++) begin
      r  = circuit(3'(v));
      gd = ((v >> 2) & (v >> 1) & 1) != 0 || (v & 1) == 0;
      ge = (v & 1) == 0;
      if (r[1] != gd || r[0] != ge) begin
        if (err == 0) first = v;
        err++;
      end
    end
  endtask

  // One full run on the selected instance; optional ignored start pulse mid-run
  task automatic run(input string tag, input int per, input bit repulse);
    int err_x, first_x, done_at;
    expect_result(err_x, first_x);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".start_busy"}, o_busy, 1);
    check({tag, ".start_clear"}, {o_done, o_pass, o_fv, o_err}, 0);
    done_at = -1;
    for (int c = 1; c <= 8 * per + 6 && done_at < 0; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (repulse && c == 5) start = 1'b1;
      if (c % per == 1 % per && c < 8 * per && (c - 1) / per < 8)
        if ((c - 1) % per == 0)
          check($sformatf("%s.vec%0d", tag, (c - 1) / per), o_abc, (c - 1) / per);
      if (o_done) done_at = c;
    end
    start = 1'b0;
    check({tag, ".done_lat"}, done_at, 8 * per);
    check({tag, ".busy_end"}, o_busy, 0);
    check({tag, ".abc_hold"}, o_abc, 7);
    check({tag, ".err"}, o_err, err_x);
    check({tag, ".pass"}, o_pass, err_x == 0);
    check({tag, ".fail_valid"}, o_fv, err_x != 0);
    if (err_x != 0) check({tag, ".fail_vec"}, o_fvec, first_x);
  endtask

  initial begin
    d_tbl  = 8'b1101_0101;
    e_tbl  = 8'b0101_0101;
    mode   = 0;
    flip_d = '0;
    flip_e = '0;
    sel    = 1'b0;
    start  = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.settle2", {busy2, done2, pass2, fv2, err2, fvec2, a2, b2, c2}, 0);
    check("rst.settle0", {busy0, done0, pass0, fv0, err0, fvec0, a0, b0, c0}, 0);
    @(negedge clk) reset = 1'b0;

    run("good", 4, 1'b0);
    mode = 1; run("d_stuck0", 4, 1'b0);
    mode = 2; run("e_is_c", 4, 1'b0);
    mode = 0; run("restart_after_fail", 4, 1'b0);
    run("repulse", 4, 1'b1);
    sel = 1'b1;
    run("s0_good", 2, 1'b0);
    mode = 1; run("s0_d_stuck0", 2, 1'b0);
    sel = 1'b0;

    // Reset while vector 011 is settling (after edge E0+13)
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("pre_reset.abc", o_abc, 3);
    check("pre_reset.err", o_err, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_reset", {o_busy, o_done, o_pass, o_fv, o_err, o_fvec, o_abc}, 0);
    mode = 0; run("after_reset", 4, 1'b0);

    // Randomly corrupted circuits on both instances
    mode = 3;
    for (int i = 0; i < 6; i++) begin
      flip_d = 8'($urandom & $urandom);
      flip_e = 8'($urandom & $urandom & $urandom);
      sel = i[0];
      run($sformatf("rand%0d", i), sel ? 2 : 4, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/simple_circuit_checker.md
Name: simple_circuit_checker

Overview:
- Synthesizable self-checking driver for the Simple_Circuit block: applies all 8 combinations of A, B and C to the circuit, waits a settle window, samples D and E, and compares them against a built-in golden model.
- Acts as the hardware counterpart of the simulation stimulus/monitor bench, so the circuit can be checked on board.
- Reports pass/fail, the error count, and the first failing vector.

Parameters:
- SETTLE_CYCLES, 2, number of idle cycles between driving a vector and sampling D/E; range 0..15.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a check run; sampled only in IDLE or DONE.
- a_out  output  1  drive to Simple_Circuit A; equals vec[2].
- b_out  output  1  drive to Simple_Circuit B; equals vec[1].
- c_out  output  1  drive to Simple_Circuit C; equals vec[0].
- d_in  input  1  Simple_Circuit D response.
- e_in  input  1  Simple_Circuit E response.
- busy  output  1  high while a run is in progress (DRIVE, SETTLE, SAMPLE).
- done  output  1  high in DONE; held until the next start or reset.
- pass  output  1  valid when done=1; 1 when err_count==0.
- err_count  output  4  number of mismatching vectors in the current/last run (0..8).
- fail_valid  output  1  a mismatch has been recorded in this run.
- fail_vec  output  3  {A,B,C} of the first mismatching vector; valid when fail_valid=1.

Behaviour:
- Reset values, applied at the clock edge with reset=1 and overriding everything:
  - state=IDLE, vec=0, a/b/c_out=0
  - busy=0, done=0, pass=0
  - err_count=0, fail_valid=0, fail_vec=0
  - settle counter=0
- All outputs are registered; a/b/c_out are driven from the vec register.
- Golden model: exp_D = (A & B) | ~C, exp_E = ~C.
  - Expected D by vector 000..111: 1,0,1,0,1,0,1,1.
  - Expected E by vector: 1,0,1,0,1,0,1,0.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
  - IDLE/DONE with start=1 -> DRIVE. The same edge sets vec=0 and clears err_count, fail_valid, fail_vec, done and pass. start=0 -> stay.
  - DRIVE (1 cycle) -> SETTLE and load counter = SETTLE_CYCLES-1. If SETTLE_CYCLES=0, go directly to SAMPLE.
  - SETTLE: decrement the counter; when the counter is 0 -> SAMPLE.
  - SAMPLE (1 cycle): compare d_in/e_in against the golden model for the current vec.
    - On mismatch: err_count+1. If fail_valid=0, set fail_valid=1 and fail_vec=vec.
    - If vec==7 -> DONE with done=1 and pass=(final err_count==0), where the final count includes this sample.
    - Otherwise vec+1 -> DRIVE.
- Latency:
  - Each vector occupies SETTLE_CYCLES+2 cycles.
  - With start sampled at edge E0, done rises at edge E0 + 8*(SETTLE_CYCLES+2). That is E0+32 at the default setting.
- busy is 1 exactly when the state is DRIVE, SETTLE or SAMPLE.
- start asserted while busy is ignored and does not restart the run.
- start held high in DONE begins a new run on the next edge; done drops that same edge.
- vec does not wrap during a run; the run ends at 7. In DONE, vec and a/b/c_out hold at 7.
- err_count saturation is not needed, since the maximum is 8.
- Reset mid-run aborts immediately to the reset values; no partial results are retained.
- d_in/e_in are used only in the SAMPLE cycle; values in other states have no effect.

Test Plan:
- Correct model (D=(A&B)|~C, E=~C from the bench), SETTLE_CYCLES=2, start pulse at E0 -> a/b/c_out step 000..111 every 4 cycles; done=1 at E0+32; pass=1, err_count=0, fail_valid=0.
- D stuck at 0 -> done with pass=0, err_count=5 (vectors 000, 010, 100, 110, 111), fail_valid=1, fail_vec=000.
- E wired as C instead of ~C -> err_count=8, fail_vec=000, pass=0.
- SETTLE_CYCLES=0, correct model -> done at E0+16; vec advances every 2 cycles; pass=1.
- reset=1 for one cycle while in SETTLE of vector 011 -> next cycle: IDLE, a/b/c_out=000, busy=0, err_count=0, done=0. A subsequent start produces a normal full run.
- start re-pulsed mid-run (busy=1) -> ignored, done at the original E0+32. start in DONE after a failing run -> err_count and fail_valid cleared on that edge, new run completes with pass=1.
